ac97_dma_sched: RTL and testbench
=================================

// Module: ac97_dma_sched
// PURPOSE
//  Schedules the AC97 DMA traffic onto one shared Wishbone master port.
//  Two requesters share that port: downstream playback reads (dmar) and upstream capture writes (dmaw).
//  Sits between the AC97 control/DMA-pointer registers and the system bus.
//  - Turns per-frame sample demands into single 32-bit bus cycles.
//  - Arbitrates round-robin between the two requesters.
//  - Pulses dmar_next/dmaw_next so the pointer registers advance.
// PARAMETERS
//  TIMEOUT   64   bus cycles without wbm_ack_i before the cycle is aborted (>=2)
//  CNT_W     8    width of the saturating underrun/overrun/error counters
// PORTS
//  sys_clk         in   1      system clock
//  sys_rst         in   1      synchronous reset, active-high
//  dmar_en         in   1      playback DMA enabled
//  dmar_addr       in   30     playback word address
//  dmar_remaining  in   16     playback words left
//  dmar_next       out  1      1-cycle pulse: one playback word consumed
//  dmaw_en         in   1      capture DMA enabled
//  dmaw_addr       in   30     capture word address
//  dmaw_remaining  in   16     capture words left
//  dmaw_next       out  1      1-cycle pulse: one capture word stored
//  down_req        in   1      pulse: codec needs the sample for the next frame
//  down_sample     out  32     playback sample {left[31:16], right[15:0]}
//  down_valid      out  1      1-cycle pulse: down_sample updated
//  up_valid        in   1      pulse: captured sample on up_sample
//  up_sample       in   32     captured sample {left, right}
//  wbm_adr_o       out  32     {addr, 2'b00}
//  wbm_dat_o       out  32     write data
//  wbm_dat_i       in   32     read data
//  wbm_we_o        out  1      1 = write
//  wbm_cyc_o       out  1      bus cycle
//  wbm_stb_o       out  1      strobe; always equal to wbm_cyc_o
//  wbm_ack_i       in   1      bus acknowledge
//  underrun_cnt    out  CNT_W  saturating count of down_req while a read is still pending
//  overrun_cnt     out  CNT_W  saturating count of up_valid while a write is still pending
//  bus_err         out  1      1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset values: all outputs 0; rd_pend/wr_pend = 0; last_grant = WRITE; state = IDLE.
//  Reset mid-cycle: wbm_cyc_o/stb_o drop in the cycle after reset is sampled; no next pulse is issued.
//  Pending flags:
//   - down_req sets rd_pend. If rd_pend is already set: underrun_cnt += 1 (saturating), flag stays set.
//   - up_valid latches up_sample into wbuf and sets wr_pend.
//   - If wr_pend is already set: wbuf is overwritten and overrun_cnt += 1 (saturating).
//  Disabled/exhausted paths (serviced in IDLE, no bus cycle):
//   - rd_pend with (~dmar_en | dmar_remaining==0): next cycle down_sample=0, down_valid=1, rd_pend cleared.
//   - wr_pend with (~dmaw_en | dmaw_remaining==0): wr_pend cleared, sample dropped, no pulse.
//  FSM: IDLE, READ, WRITE.
//   - IDLE: grant an eligible pending request. If both are eligible, grant the one not equal to last_grant.
//   - On grant, next cycle: cyc=stb=1 and adr={addr,2'b00}; we=1 plus dat_o=wbuf for WRITE.
//   - The address is sampled at grant and held for the whole cycle.
//   - READ, on ack (cycle M), at M+1:
//     - cyc=stb=0; down_sample=wbm_dat_i captured at M; down_valid=1; dmar_next=1.
//     - rd_pend cleared (unless a new down_req arrived at M: that counts as underrun, rd_pend stays set).
//     - last_grant=READ; state=IDLE.
//   - WRITE, on ack at M: M+1 cyc=0, dmaw_next=1, last_grant=WRITE, IDLE.
//     - wr_pend cleared unless up_valid at M re-set it.
//   - Minimum turnaround: one IDLE cycle between bus cycles.
//  Timeout: a watchdog counts cycles with cyc=1 and no ack.
//   - At count TIMEOUT-1: next cycle cyc=0, bus_err=1, no next pulse, pending flag cleared, IDLE.
//   - For READ, down_sample is left unchanged and down_valid=0 (the codec replays the old sample).
//  Simultaneous: down_req and up_valid in the same cycle both set their flags. Ack and a new request in the same cycle: see above.
//  Counters saturate at 2^CNT_W-1 and clear only on reset.
// STRUCTURE
//  Shared header ac97_defs.vh: FSM state encodings (IDLE/READ/WRITE), grant encoding.
//  Sub-module ac97_rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant -> grant).
//  Counters and watchdog stay inline.
// TESTING
//  1. down_req, dmar_en=1, rem=4, addr=0x100; ack after 3 cycles with dat_i=0xAAAA5555
//     -> adr=0x400, we=0; down_sample=0xAAAA5555; down_valid and dmar_next one pulse each.
//  2. up_valid with sample 0x12345678, dmaw_en=1, addr=0x200
//     -> adr=0x800, we=1, dat_o=0x12345678; dmaw_next pulse after ack.
//  3. down_req and up_valid same cycle, last_grant=WRITE -> READ first, then WRITE; repeat -> order alternates.
//  4. dmar_en=0, down_req -> no cyc; down_sample=0 with down_valid pulse 1 cycle later.
//     dmaw_remaining=0, up_valid -> no bus activity.
//  5. ack never returned, TIMEOUT=64 -> cyc drops after 64 cycles; bus_err pulse; no dmar_next.
//  6. Two down_req pulses during one stalled read -> underrun_cnt=1; exactly one read follows the ack.
//     Assert sys_rst mid-cycle -> cyc=0 next cycle, counters=0.

Source files
------------

// File: rtl/ac97_dma_sched_pkg.sv
// Shared types for the AC97 DMA scheduler: FSM state encoding, grant
// encoding and the word-to-byte address helper.
package ac97_dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic GNT_READ  = 1'b0;
    localparam logic GNT_WRITE = 1'b1;

    function automatic logic [31:0] word_to_byte_adr(input logic [29:0] word_adr);
        return {word_adr, 2'b00};
    endfunction

endpackage

// File: rtl/ac97_dma_sched_rr_arb2.sv
// Two-way round-robin arbiter between playback reads (req[0]) and capture
// writes (req[1]); on contention the requester not served last wins.
module ac97_dma_sched_rr_arb2
    import ac97_dma_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    // Grant selection
    always_comb begin
        grant_valid = 1'b0;
        grant       = GNT_READ;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant       = GNT_READ;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant       = GNT_WRITE;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (last_grant == GNT_WRITE) begin
                    grant = GNT_READ;
                end else begin
                    grant = GNT_WRITE;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant       = GNT_READ;
            end
        endcase
    end

endmodule

// File: rtl/ac97_dma_sched.sv
// Schedules AC97 playback reads and capture writes onto one Wishbone master
// port as single 32-bit cycles, with a no-ack watchdog and overflow counters.
module ac97_dma_sched
    import ac97_dma_sched_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             dmar_en,
    input  logic [29:0]      dmar_addr,
    input  logic [15:0]      dmar_remaining,
    output logic             dmar_next,
    input  logic             dmaw_en,
    input  logic [29:0]      dmaw_addr,
    input  logic [15:0]      dmaw_remaining,
    output logic             dmaw_next,
    input  logic             down_req,
    output logic [31:0]      down_sample,
    output logic             down_valid,
    input  logic             up_valid,
    input  logic [31:0]      up_sample,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    output logic             wbm_we_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    input  logic             wbm_ack_i,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             bus_err
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    state_e            state_r, state_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic              rd_pend_r, rd_pend_nxt_s;
    logic              wr_pend_r, wr_pend_nxt_s;
    logic [31:0]       wbuf_r, wbuf_nxt_s;
    logic [WD_W-1:0]   wd_r, wd_nxt_s;
    logic              cyc_r, cyc_nxt_s;
    logic              we_r, we_nxt_s;
    logic [31:0]       adr_r, adr_nxt_s;
    logic [31:0]       dat_r, dat_nxt_s;
    logic [31:0]       down_sample_r, down_sample_nxt_s;
    logic              down_valid_r, down_valid_nxt_s;
    logic              dmar_next_r, dmar_next_nxt_s;
    logic              dmaw_next_r, dmaw_next_nxt_s;
    logic              bus_err_r, bus_err_nxt_s;
    logic [CNT_W-1:0]  underrun_r, underrun_nxt_s;
    logic [CNT_W-1:0]  overrun_r, overrun_nxt_s;

    logic rd_elig_s, wr_elig_s, rd_drop_s, wr_drop_s;
    logic grant_valid_s, grant_s;

    assign rd_elig_s = rd_pend_r & dmar_en & (dmar_remaining != 16'd0);
    assign wr_elig_s = wr_pend_r & dmaw_en & (dmaw_remaining != 16'd0);
    assign rd_drop_s = rd_pend_r & ~rd_elig_s;
    assign wr_drop_s = wr_pend_r & ~wr_elig_s;

    ac97_dma_sched_rr_arb2 u_arb (
        .req         ({wr_elig_s, rd_elig_s}),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Next-state, pending-flag and output computation
    always_comb begin
        state_nxt_s       = state_r;
        last_grant_nxt_s  = last_grant_r;
        rd_pend_nxt_s     = rd_pend_r;
        wr_pend_nxt_s     = wr_pend_r;
        wbuf_nxt_s        = wbuf_r;
        wd_nxt_s          = wd_r;
        cyc_nxt_s         = cyc_r;
        we_nxt_s          = we_r;
        adr_nxt_s         = adr_r;
        dat_nxt_s         = dat_r;
        down_sample_nxt_s = down_sample_r;
        down_valid_nxt_s  = 1'b0;
        dmar_next_nxt_s   = 1'b0;
        dmaw_next_nxt_s   = 1'b0;
        bus_err_nxt_s     = 1'b0;
        underrun_nxt_s    = underrun_r;
        overrun_nxt_s     = overrun_r;

        if (down_req) begin
            rd_pend_nxt_s = 1'b1;
            if (rd_pend_r) begin
                underrun_nxt_s = sat_inc(underrun_r);
            end else begin
                underrun_nxt_s = underrun_r;
            end
        end else begin
            rd_pend_nxt_s = rd_pend_r;
        end

        if (up_valid) begin
            wr_pend_nxt_s = 1'b1;
            wbuf_nxt_s    = up_sample;
            if (wr_pend_r) begin
                overrun_nxt_s = sat_inc(overrun_r);
            end else begin
                overrun_nxt_s = overrun_r;
            end
        end else begin
            wr_pend_nxt_s = wr_pend_r;
        end

        // A request arriving in the completion cycle keeps its flag set.
        case (state_r)
            ST_IDLE: begin
                wd_nxt_s = {WD_W{1'b0}};
                if (rd_drop_s) begin
                    down_sample_nxt_s = 32'h0000_0000;
                    down_valid_nxt_s  = 1'b1;
                    rd_pend_nxt_s     = down_req;
                end else begin
                    down_valid_nxt_s  = 1'b0;
                end
                if (wr_drop_s) begin
                    wr_pend_nxt_s = up_valid;
                end else begin
                    dmaw_next_nxt_s = 1'b0;
                end
                if (grant_valid_s) begin
                    cyc_nxt_s = 1'b1;
                    if (grant_s == GNT_READ) begin
                        state_nxt_s = ST_READ;
                        we_nxt_s    = 1'b0;
                        adr_nxt_s   = word_to_byte_adr(dmar_addr);
                    end else begin
                        state_nxt_s = ST_WRITE;
                        we_nxt_s    = 1'b1;
                        adr_nxt_s   = word_to_byte_adr(dmaw_addr);
                        dat_nxt_s   = wbuf_r;
                    end
                end else begin
                    cyc_nxt_s = 1'b0;
                end
            end
            ST_READ: begin
                if (wbm_ack_i) begin
                    cyc_nxt_s         = 1'b0;
                    we_nxt_s          = 1'b0;
                    state_nxt_s       = ST_IDLE;
                    last_grant_nxt_s  = GNT_READ;
                    down_sample_nxt_s = wbm_dat_i;
                    down_valid_nxt_s  = 1'b1;
                    dmar_next_nxt_s   = 1'b1;
                    rd_pend_nxt_s     = down_req;
                end else if (wd_r == WD_LAST) begin
                    cyc_nxt_s        = 1'b0;
                    state_nxt_s      = ST_IDLE;
                    last_grant_nxt_s = GNT_READ;
                    bus_err_nxt_s    = 1'b1;
                    rd_pend_nxt_s    = down_req;
                end else begin
                    wd_nxt_s = wd_r + WD_W'(1);
                end
            end
            ST_WRITE: begin
                if (wbm_ack_i) begin
                    cyc_nxt_s        = 1'b0;
                    we_nxt_s         = 1'b0;
                    state_nxt_s      = ST_IDLE;
                    last_grant_nxt_s = GNT_WRITE;
                    dmaw_next_nxt_s  = 1'b1;
                    wr_pend_nxt_s    = up_valid;
                end else if (wd_r == WD_LAST) begin
                    cyc_nxt_s        = 1'b0;
                    we_nxt_s         = 1'b0;
                    state_nxt_s      = ST_IDLE;
                    last_grant_nxt_s = GNT_WRITE;
                    bus_err_nxt_s    = 1'b1;
                    wr_pend_nxt_s    = up_valid;
                end else begin
                    wd_nxt_s = wd_r + WD_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cyc_nxt_s   = 1'b0;
                we_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GNT_WRITE;
            rd_pend_r     <= 1'b0;
            wr_pend_r     <= 1'b0;
            wbuf_r        <= 32'h0000_0000;
            wd_r          <= {WD_W{1'b0}};
            cyc_r         <= 1'b0;
            we_r          <= 1'b0;
            adr_r         <= 32'h0000_0000;
            dat_r         <= 32'h0000_0000;
            down_sample_r <= 32'h0000_0000;
            down_valid_r  <= 1'b0;
            dmar_next_r   <= 1'b0;
            dmaw_next_r   <= 1'b0;
            bus_err_r     <= 1'b0;
            underrun_r    <= {CNT_W{1'b0}};
            overrun_r     <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            rd_pend_r     <= rd_pend_nxt_s;
            wr_pend_r     <= wr_pend_nxt_s;
            wbuf_r        <= wbuf_nxt_s;
            wd_r          <= wd_nxt_s;
            cyc_r         <= cyc_nxt_s;
            we_r          <= we_nxt_s;
            adr_r         <= adr_nxt_s;
            dat_r         <= dat_nxt_s;
            down_sample_r <= down_sample_nxt_s;
            down_valid_r  <= down_valid_nxt_s;
            dmar_next_r   <= dmar_next_nxt_s;
            dmaw_next_r   <= dmaw_next_nxt_s;
            bus_err_r     <= bus_err_nxt_s;
            underrun_r    <= underrun_nxt_s;
            overrun_r     <= overrun_nxt_s;
        end
    end

    assign wbm_cyc_o    = cyc_r;
    assign wbm_stb_o    = cyc_r;
    assign wbm_we_o     = we_r;
    assign wbm_adr_o    = adr_r;
    assign wbm_dat_o    = dat_r;
    assign down_sample  = down_sample_r;
    assign down_valid   = down_valid_r;
    assign dmar_next    = dmar_next_r;
    assign dmaw_next    = dmaw_next_r;
    assign bus_err      = bus_err_r;
    assign underrun_cnt = underrun_r;
    assign overrun_cnt  = overrun_r;

endmodule

// File: tb/tb_ac97_dma_sched.sv
// Scoreboard bench for ac97_dma_sched: stimulus queues expected bus/codec
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_ac97_dma_sched;

    localparam int EV_CYC = 0;
    localparam int EV_DV  = 1;
    localparam int EV_RN  = 2;
    localparam int EV_WN  = 3;
    localparam int EV_ERR = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        dmar_en, dmaw_en, down_req, up_valid;
    logic [29:0] dmar_addr, dmaw_addr;
    logic [15:0] dmar_remaining, dmaw_remaining;
    logic [31:0] up_sample, wbm_dat_i;
    logic        wbm_ack_i;
    logic        dmar_next, dmaw_next, down_valid, wbm_we_o, wbm_cyc_o, wbm_stb_o, bus_err;
    logic [31:0] down_sample, wbm_adr_o, wbm_dat_o;
    logic [7:0]  underrun_cnt, overrun_cnt;

    always #5 sys_clk = ~sys_clk;

    ac97_dma_sched #(.TIMEOUT(64), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .dmar_en(dmar_en), .dmar_addr(dmar_addr), .dmar_remaining(dmar_remaining), .dmar_next(dmar_next),
        .dmaw_en(dmaw_en), .dmaw_addr(dmaw_addr), .dmaw_remaining(dmaw_remaining), .dmaw_next(dmaw_next),
        .down_req(down_req), .down_sample(down_sample), .down_valid(down_valid),
        .up_valid(up_valid), .up_sample(up_sample),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
        .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt), .bus_err(bus_err)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          ack_lat = 3;
    logic [31:0] rd_data = 32'h0;
    int          age = 0;
    logic        prev_cyc = 1'b0;
    int          cyc_len = 0;

    function automatic string kname(input int k);
        case (k)
            EV_CYC:  return "bus_cycle";
            EV_DV:   return "down_valid";
            EV_RN:   return "dmar_next";
            EV_WN:   return "dmaw_next";
            EV_ERR:  return "bus_err";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [31:0] a, input logic we, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.a = a; e.we = we; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic we, input logic [31:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s: got a=%h we=%b d=%h, want no event", kname(kind), a, we, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a ||
                (kind == EV_CYC && (e.we !== we || (we && e.d !== d)))) begin
                bad++;
                $display("FAIL %s: got %s a=%h we=%b d=%h, want %s a=%h we=%b d=%h",
                         kname(e.kind), kname(kind), a, we, d, kname(e.kind), e.a, e.we, e.d);
            end
        end
    endtask

    // Wishbone slave: ack in the ack_lat-th cycle of a bus cycle, never when ack_lat==0
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(posedge sys_clk);
            #1;
            wbm_dat_i = rd_data;
            if (wbm_cyc_o) begin
                age = age + 1;
                wbm_ack_i = (ack_lat > 0 && age == ack_lat);
            end else begin
                age = 0;
                wbm_ack_i = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (wbm_cyc_o && !prev_cyc) begin
                check("stb_eq_cyc", {31'd0, wbm_stb_o}, 32'd1);
                observe(EV_CYC, wbm_adr_o, wbm_we_o, wbm_dat_o);
            end
            if (down_valid) observe(EV_DV, down_sample, 1'b0, 32'h0);
            if (dmar_next)  observe(EV_RN, 32'h0, 1'b0, 32'h0);
            if (dmaw_next)  observe(EV_WN, 32'h0, 1'b0, 32'h0);
            if (bus_err)    observe(EV_ERR, 32'(cyc_len), 1'b0, 32'h0);
        end
        if (wbm_cyc_o) cyc_len = prev_cyc ? cyc_len + 1 : 1;
        prev_cyc = wbm_cyc_o;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_down();
        down_req = 1'b1; step(1); down_req = 1'b0;
    endtask

    task automatic pulse_up(input logic [31:0] s);
        up_sample = s; up_valid = 1'b1; step(1); up_valid = 1'b0;
    endtask

    task automatic pulse_both(input logic [31:0] s);
        up_sample = s; up_valid = 1'b1; down_req = 1'b1; step(1);
        up_valid = 1'b0; down_req = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step(1);
            n++;
        end
        check("events_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step(8);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        sys_rst = 1'b1;
        dmar_en = 1'b1; dmar_addr = 30'h100; dmar_remaining = 16'd4;
        dmaw_en = 1'b1; dmaw_addr = 30'h200; dmaw_remaining = 16'd4;
        down_req = 1'b0; up_valid = 1'b0; up_sample = 32'h0;
        step(2);
        @(negedge sys_clk);
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_down_sample", down_sample, 32'h0);
        check("rst_counters", {16'd0, underrun_cnt, overrun_cnt}, 32'h0);
        check("rst_pulses", {28'd0, down_valid, dmar_next, dmaw_next, bus_err}, 32'h0);
        sys_rst = 1'b0;
        step(1);

        // 1: single playback read, ack in third cycle
        ack_lat = 3; rd_data = 32'hAAAA5555;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'hAAAA5555, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_down();
        drain(40);

        // 2: single capture write
        ack_lat = 2;
        expect_ev(EV_CYC, 32'h0000_0800, 1'b1, 32'h12345678);
        expect_ev(EV_WN, 32'h0, 1'b0, 32'h0);
        pulse_up(32'h12345678);
        drain(40);

        // 3a: contention after a write -> read first
        rd_data = 32'h2468ACE0;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h2468ACE0, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        expect_ev(EV_CYC, 32'h0000_0800, 1'b1, 32'h0F0F0F0F);
        expect_ev(EV_WN, 32'h0, 1'b0, 32'h0);
        pulse_both(32'h0F0F0F0F);
        drain(60);

        // 3b: lone read, then contention -> write first; top word address
        rd_data = 32'h0BADF00D;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h0BADF00D, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_down();
        drain(40);
        dmar_addr = 30'h3FFF_FFFF; rd_data = 32'h76543210;
        expect_ev(EV_CYC, 32'h0000_0800, 1'b1, 32'hA5A5A5A5);
        expect_ev(EV_WN, 32'h0, 1'b0, 32'h0);
        expect_ev(EV_CYC, 32'hFFFF_FFFC, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h76543210, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_both(32'hA5A5A5A5);
        drain(60);
        dmar_addr = 30'h100;

        // 5: no ack -> abort after 64 cycles, old sample kept
        ack_lat = 0;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_ERR, 32'd64, 1'b0, 32'h0);
        pulse_down();
        drain(120);
        check("timeout_keeps_sample", down_sample, 32'h76543210);

        // 4: disabled playback answers with silence; exhausted capture is dropped
        ack_lat = 3; dmar_en = 1'b0;
        expect_ev(EV_DV, 32'h0, 1'b0, 32'h0);
        pulse_down();
        drain(20);
        dmar_en = 1'b1; dmaw_remaining = 16'd0;
        pulse_up(32'hDEADBEEF);
        drain(20);
        dmaw_remaining = 16'd4;

        // 6: extra request during a stalled read -> one underrun, one read
        ack_lat = 10; rd_data = 32'h11112222;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h11112222, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_down();
        step(4);
        pulse_down();
        drain(60);
        check("underrun_one", {24'd0, underrun_cnt}, 32'd1);

        // 6b: request in the ack cycle keeps the flag -> a second read follows
        rd_data = 32'h33334444;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h33334444, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h33334444, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_down();
        n = 0;
        do begin
            @(posedge sys_clk);
            #2;
            n++;
        end while (!wbm_ack_i && n < 50);
        check("ack_seen", {31'd0, wbm_ack_i}, 32'd1);
        down_req = 1'b1;
        @(posedge sys_clk);
        #1;
        down_req = 1'b0;
        drain(80);
        check("underrun_two", {24'd0, underrun_cnt}, 32'd2);

        // overrun: second capture sample while the write is stalled
        ack_lat = 5;
        expect_ev(EV_CYC, 32'h0000_0800, 1'b1, 32'h55AA55AA);
        expect_ev(EV_WN, 32'h0, 1'b0, 32'h0);
        pulse_up(32'h55AA55AA);
        step(2);
        pulse_up(32'hCAFEF00D);
        drain(40);
        check("overrun_one", {24'd0, overrun_cnt}, 32'd1);

        // reset in the middle of a stalled cycle
        ack_lat = 0;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        pulse_down();
        step(5);
        check("cyc_before_reset", {31'd0, wbm_cyc_o}, 32'd1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("reset_counters", {16'd0, underrun_cnt, overrun_cnt}, 32'h0);
        check("reset_pulses", {28'd0, down_valid, dmar_next, dmaw_next, bus_err}, 32'h0);
        sys_rst = 1'b0;
        step(1);
        drain(5);

        // read still works after reset
        ack_lat = 2; rd_data = 32'h13579BDF;
        expect_ev(EV_CYC, 32'h0000_0400, 1'b0, 32'h0);
        expect_ev(EV_DV, 32'h13579BDF, 1'b0, 32'h0);
        expect_ev(EV_RN, 32'h0, 1'b0, 32'h0);
        pulse_down();
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
